// File: rtl/nmr_bstrm_simp_dpath_if.sv
// Segment bus between the sequence controller and the bitstream datapath.
// The controller side (master) issues segments; the datapath (slave) drives
// the serial output and the next-segment request.
interface nmr_bstrm_simp_dpath_if #(
  parameter int DATA_WIDTH = 24,
  parameter int MUX_WIDTH  = 16
);
  logic                  START;
  logic                  DPATH_RDY;
  logic [DATA_WIDTH-1:0] data;
  logic                  PLS_POL;
  logic [3:0]            mux_sel;
  logic [MUX_WIDTH-2:0]  mux_in;
  logic                  OUT;

  modport master (
    output START,
    output data,
    output PLS_POL,
    output mux_sel,
    output mux_in,
    input  DPATH_RDY,
    input  OUT
  );

  modport slave (
    input  START,
    input  data,
    input  PLS_POL,
    input  mux_sel,
    input  mux_in,
    output DPATH_RDY,
    output OUT
  );
endinterface

// File: rtl/nmr_bstrm_simp_dpath.sv
// NMR pulse-sequencer bitstream datapath: plays one segment (length,
// polarity, mux source) on OUT and requests the next segment one cycle
// before the current one ends so back-to-back segments are gapless.
module nmr_bstrm_simp_dpath #(
  parameter int DATA_WIDTH = 24,
  parameter int MUX_WIDTH  = 16
) (
  input logic                  CLK,
  input logic                  RST,
  nmr_bstrm_simp_dpath_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pol_l_q, pol_l_d;
  logic [3:0]            sel_l_q, sel_l_d;
  logic                  out_q, out_d;
  logic [DATA_WIDTH-1:0] len;
  logic                  start_lvl;
  logic                  run_lvl;
  logic                  rdy;

  // Select space is always 16 wide; entries beyond the real mux tie to 0,
  // entry 0 is unused since select 0 means "use the polarity".
  logic [15:0] src_ext;
  assign src_ext[0] = 1'b0;
  for (genvar gi = 1; gi < 16; gi++) begin : g_src
    if (gi < MUX_WIDTH) begin : g_live
      assign src_ext[gi] = bus.mux_in[gi-1];
    end else begin : g_tie
      assign src_ext[gi] = 1'b0;
    end
  end

  // Segment length clamp (0/1 -> 2 so a request pulse always exists) and the
  // output level for a fresh segment and for a running one.
  always_comb begin
    len       = (bus.data < DATA_WIDTH'(2)) ? DATA_WIDTH'(2) : bus.data;
    start_lvl = (bus.mux_sel == 4'd0) ? bus.PLS_POL : src_ext[bus.mux_sel];
    run_lvl   = (sel_l_q == 4'd0) ? pol_l_q : src_ext[sel_l_q];
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pol_l_q <= 1'b0;
      sel_l_q <= 4'd0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pol_l_q <= pol_l_d;
      sel_l_q <= sel_l_d;
      out_q   <= out_d;
    end
  end

  // Next state: START wins in any state; RUN counts down and re-samples the
  // selected source, then drops to IDLE holding the last output level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pol_l_d = pol_l_q;
    sel_l_d = sel_l_q;
    out_d   = out_q;
    if (bus.START) begin
      state_d = RUN;
      cnt_d   = len - DATA_WIDTH'(1);
      pol_l_d = bus.PLS_POL;
      sel_l_d = bus.mux_sel;
      out_d   = start_lvl;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DATA_WIDTH'(1);
        out_d = run_lvl;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Request: single pulse at cnt==1 while running, steady level when idle.
  always_comb begin
    rdy = 1'b1;
    if (state_q == RUN) begin
      rdy = (cnt_q == DATA_WIDTH'(1));
    end
  end

  assign bus.DPATH_RDY = rdy;
  assign bus.OUT       = out_q;

endmodule

// File: tb/tb_nmr_bstrm_simp_dpath.sv
// Directed bench for the NMR bitstream datapath. Each cycle pushes the
// expected post-edge OUT/DPATH_RDY onto a scoreboard and pops it after the
// edge. Expectations follow the segment timing: sample i after the START
// edge shows the segment level for i < len (and it holds afterwards), and
// DPATH_RDY is high at i == len-2 and again from i == len (idle) onward.
module tb_nmr_bstrm_simp_dpath;

  localparam int DW = 24;
  localparam int MW = 8;

  typedef struct {
    bit    eo;
    bit    er;
    string tag;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic obs_out;
  logic obs_rdy;

  nmr_bstrm_simp_dpath_if #(.DATA_WIDTH(DW), .MUX_WIDTH(MW)) bus ();

  nmr_bstrm_simp_dpath #(.DATA_WIDTH(DW), .MUX_WIDTH(MW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input bit r, input bit st, input int dat, input bit pol,
                      input int sel, input logic [MW-2:0] min,
                      input bit eo, input bit er, input string tag);
    exp_t e;
    rst         = r;
    bus.START   = st;
    bus.data    = DW'(dat);
    bus.PLS_POL = pol;
    bus.mux_sel = 4'(sel);
    bus.mux_in  = min;
    e.eo  = eo;
    e.er  = er;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #2;
    e = sb.pop_front();
    obs_out = bus.OUT;
    obs_rdy = bus.DPATH_RDY;
    checks++;
    assert (obs_out === e.eo) else begin
      errors++;
      $error("FAIL %s OUT observed=%0b expected=%0b", e.tag, obs_out, e.eo);
    end
    checks++;
    assert (obs_rdy === e.er) else begin
      errors++;
      $error("FAIL %s DPATH_RDY observed=%0b expected=%0b", e.tag, obs_rdy, e.er);
    end
  endtask

  // Idle-cycle tick: unused inputs are randomised since they must be ignored.
  task automatic idle(input logic [MW-2:0] min, input bit eo, input bit er,
                      input string tag);
    tick(1'b0, 1'b0, int'($urandom_range(0, 1000)), 1'($urandom),
         int'($urandom_range(0, 15)), min, eo, er, tag);
  endtask

  // One segment with mux_sel=0 followed by 'extra' cycles with no START.
  task automatic seg(input int dat, input bit pol, input int extra, input string tag);
    int len;
    len = (dat < 2) ? 2 : dat;
    $display("segment %s: data=%0d pol=%0b len=%0d", tag, dat, pol, len);
    tick(1'b0, 1'b1, dat, pol, 0, '0, pol, (len == 2), tag);
    for (int i = 1; i < len + extra; i++)
      idle('0, pol, (i == len - 2) || (i >= len), tag);
  endtask

  int   b2b_d[3] = '{5, 7, 6};
  bit   b2b_p[3] = '{1'b1, 1'b0, 1'b1};
  logic [MW-2:0] m;
  bit   last;

  initial begin
    rst         = 1'b1;
    bus.START   = 1'b0;
    bus.data    = '0;
    bus.PLS_POL = 1'b0;
    bus.mux_sel = '0;
    bus.mux_in  = '0;

    // Reset held two cycles, then 20 quiet cycles.
    $display("reset: 2 cycles, then 20 idle cycles");
    tick(1'b1, 1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1, "reset");
    tick(1'b1, 1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1, "reset");
    for (int i = 0; i < 20; i++) idle('0, 1'b0, 1'b1, "idle_after_reset");

    // Single 10-cycle segment, then idle holding the level.
    seg(10, 1'b1, 4, "single10");

    // Back-to-back with a responder that registers DPATH_RDY and starts next.
    for (int k = 0; k < 3; k++) begin
      int len;
      int rdy_at;
      int i;
      bit done;
      len = b2b_d[k];
      $display("segment b2b%0d: data=%0d pol=%0b", k, len, b2b_p[k]);
      tick(1'b0, 1'b1, len, b2b_p[k], 0, '0, b2b_p[k], (len == 2), "b2b");
      rdy_at = obs_rdy ? 0 : -1;
      i = 1;
      done = 1'b0;
      while (!done) begin
        if (rdy_at >= 0 && i == rdy_at + 2) begin
          done = 1'b1;
        end else if (i > len + 4) begin
          checks++;
          errors++;
          $error("FAIL b2b_timeout no DPATH_RDY observed=none expected=cycle %0d", len - 2);
          done = 1'b1;
        end else begin
          idle('0, b2b_p[k], (i == len - 2) || (i >= len), "b2b");
          if (obs_rdy === 1'b1 && rdy_at < 0) rdy_at = i;
          i++;
        end
      end
      checks++;
      assert (i == len) else begin
        errors++;
        $error("FAIL b2b_gap next START at cycle observed=%0d expected=%0d", i, len);
      end
      if (k == 2) begin
        idle('0, b2b_p[k], 1'b1, "b2b_tail");
        idle('0, b2b_p[k], 1'b1, "b2b_tail");
      end
    end

    // Clamp: data 0 and 1 both behave as 2-cycle segments.
    seg(0, 1'b0, 2, "clamp0");
    seg(1, 1'b1, 2, "clamp1");

    // Mux source 3: OUT tracks mux_in[2] one cycle late, then holds.
    $display("segment mux3: data=8 sel=3 toggling mux_in[2]");
    m = 7'($urandom);
    m[2] = 1'b1;
    tick(1'b0, 1'b1, 8, 1'b0, 3, m, m[2], 1'b0, "mux3");
    for (int i = 1; i < 8; i++) begin
      m = 7'($urandom);
      m[2] = ~last;
      if (i == 1) m[2] = 1'b0;
      idle(m, m[2], (i == 6), "mux3");
      last = m[2];
    end
    m = ~m;
    idle(m, last, 1'b1, "mux3_hold");

    // Highest real source (sel 7 -> mux_in[6]), re-sampled while running.
    $display("segment mux7: data=2 sel=7");
    m = 7'b1000000;
    tick(1'b0, 1'b1, 2, 1'b0, 7, m, 1'b1, 1'b1, "mux7");
    m = 7'b0111111;
    idle(m, 1'b0, 1'b0, "mux7");
    idle(m, 1'b0, 1'b1, "mux7");

    // Select beyond the mux size reads 0 even with pol=1 and all sources 1.
    $display("segment mux15: data=3 sel=15");
    m = '1;
    tick(1'b0, 1'b1, 3, 1'b1, 15, m, 1'b0, 1'b0, "mux15");
    idle(m, 1'b0, 1'b1, "mux15");
    idle(m, 1'b0, 1'b0, "mux15");
    idle(m, 1'b0, 1'b1, "mux15");

    // Preempt a long segment at cycle 20 with a short low one.
    $display("segment preempt: data=100 pol=1, restart at cycle 20 data=4 pol=0");
    tick(1'b0, 1'b1, 100, 1'b1, 0, '0, 1'b1, 1'b0, "preempt1");
    for (int i = 1; i < 20; i++) idle('0, 1'b1, 1'b0, "preempt1");
    seg(4, 1'b0, 3, "preempt2");

    // Reset at cycle 2 of a running segment: OUT 0, idle, no pulse.
    $display("segment rst_mid: data=10 pol=1, RST at cycle 2");
    tick(1'b0, 1'b1, 10, 1'b1, 0, '0, 1'b1, 1'b0, "rst_mid");
    idle('0, 1'b1, 1'b0, "rst_mid");
    tick(1'b1, 1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1, "rst_mid");
    for (int i = 0; i < 3; i++) idle('0, 1'b0, 1'b1, "rst_mid_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nmr_bstrm_simp_dpath.md
# nmr_bstrm_simp_dpath

Bitstream datapath for the NMR pulse sequencer. It receives one segment at a time from the sequence controller: a duration in clock cycles, a polarity, and an output-mux select. It drives the serial `OUT` line for exactly that duration. One cycle before the segment ends it pulses `DPATH_RDY` so the controller can issue the next segment gaplessly.

## Interface
- `DATA_WIDTH`, default 24: width of the segment length `data`.
- `MUX_WIDTH`, default 16: mux size; `mux_in` carries `MUX_WIDTH-1` external sources.
- `CLK`  in  1  sole clock; all logic on its rising edge.
- `RST`  in  1  reset. One clock; reset is synchronous and active-high.
- `START`  in  1  one-cycle strobe: latch `data`, `PLS_POL` and `mux_sel`, and begin a segment.
- `DPATH_RDY`  out  1  next-segment request; pulse while running, level while idle.
- `data`  in  DATA_WIDTH  segment length in clock cycles, unsigned.
- `PLS_POL`  in  1  output level for the segment when `mux_sel`=0.
- `mux_sel`  in  4  0 selects `PLS_POL`; k in 1..15 selects `mux_in[k-1]`.
- `mux_in`  in  MUX_WIDTH-1  external sources, sampled live each cycle.
- `OUT`  out  1  registered bitstream output.

## Operation
- States: IDLE, RUN.
- Latched registers:
  - `cnt` (DATA_WIDTH bits).
  - `pol_l`, `sel_l` (4 bits).
- Effective length `len = (data < 2) ? 2 : data`. Values 0 and 1 are clamped to 2 so a request pulse always exists.
- Output function `f(sel, pol)`:
  - `sel==0` → `pol`.
  - `1 ≤ sel ≤ MUX_WIDTH-1` → `mux_in[sel-1]`.
  - Otherwise → 0.
- `START` sampled high, in any state, has priority over everything else:
  - `cnt <= len-1`; `pol_l <= PLS_POL`; `sel_l <= mux_sel`.
  - `OUT <= f(mux_sel, PLS_POL)`; state → RUN.
- RUN without `START`:
  - If `cnt != 0`: `cnt <= cnt-1` and `OUT <= f(sel_l, pol_l)`.
  - If `cnt == 0`: state → IDLE; `OUT` holds its last value.
- IDLE without `START`: `OUT` holds; `cnt` holds at 0.
- `DPATH_RDY` is combinational from state only:
  - In RUN: `(cnt == 1)`, which gives exactly one cycle per segment.
  - In IDLE: 1.
- A `START` arriving mid-segment aborts the current segment and reloads.
- `mux_in`, `PLS_POL`, `data` and `mux_sel` are ignored except on the `START` edge. Exception: the selected `mux_in` bit is re-sampled every RUN cycle.

## Timing
- Reset, at the rising edge with `RST`=1: state=IDLE, `cnt`=0, `pol_l`=0, `sel_l`=0, `OUT`=0, so `DPATH_RDY`=1.
- `RST` mid-segment aborts at that edge; no request pulse is emitted.
- Let E0 be the edge sampling `START`:
  - `OUT` takes the new level after E0 and holds it for `len` cycles, E0..E_len.
  - `DPATH_RDY` is high during the single cycle between E_len-2 and E_len-1.
  - A controller that registers `START` on the edge it sees `DPATH_RDY` (E_len-1) presents `START` at E_len. The next segment then starts at E_len with no gap and no extra cycle.
- If `START` is absent at E_len:
  - State goes IDLE and `OUT` holds.
  - `DPATH_RDY` rises in the following cycle and stays high.
- A controller loop needing L cycles between sampling `START` and re-sampling `DPATH_RDY` requires `data ≥ L+1` for gapless output. Shorter segments stretch through IDLE.
- Counter arithmetic: unsigned, no wrap; `cnt` never decrements below 0.

## Test plan
- Reset: hold `RST` 2 cycles → `OUT`=0, `DPATH_RDY`=1. Release; no `START` → outputs unchanged for 20 cycles.
- Single segment: `START` with `data`=10, `PLS_POL`=1, `mux_sel`=0 →
  - `OUT`=1 for exactly 10 cycles after E0.
  - `DPATH_RDY` high only in the cycle before E9.
  - IDLE after E10; `OUT` stays 1; `DPATH_RDY`=1 from then on.
- Back-to-back: a responder model asserts `START` the cycle after `DPATH_RDY`, feeding segments (5,1), (7,0), (6,1) → `OUT` is 5 ones, 7 zeros, 6 ones, contiguous with no gaps.
- Clamp: `START` with `data`=0, then with `data`=1 → each segment lasts 2 cycles and produces one `DPATH_RDY` pulse.
- Mux path: `mux_sel`=3, `data`=8, and toggle `mux_in[2]` every cycle → `OUT` follows `mux_in[2]` delayed one cycle for 8 cycles. `mux_sel`=15 with `MUX_WIDTH`=8 → `OUT`=0.
- Preempt and reset: `START` `data`=100, then a second `START` at cycle 20 with `data`=4, `PLS_POL`=0 → `OUT`=0 for 4 cycles. `RST` at cycle 2 of a new segment → `OUT`=0 and IDLE at the next edge.
